// File: rtl/ascon_perm_iter.sv
// rtl/ascon_perm_iter.sv - iterative Ascon permutation, UNROLL rounds per clock
// Optional busy-start error pulse err_o is enabled by ASCON_PERM_BUSY_ERR_EN.
package ascon_perm_pkg;
  typedef logic [4:0][63:0] type_state;
endpackage

module ascon_perm_iter
  import ascon_perm_pkg::*;
#(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  output logic       ready_o,
  output logic       valid_o,
  output type_state  state_o
`ifdef ASCON_PERM_BUSY_ERR_EN
  ,
  output logic       err_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e       fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] idx_q, idx_d;

  type_state  chain;
  logic [3:0] step;
  logic [3:0] n_eff;
  logic       accept;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
    return (x >> r) | (x << (64 - r));
  endfunction

  // One round: constant addition, bitsliced S-box, linear diffusion.
  function automatic type_state ascon_round(input type_state s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    type_state   r;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, 4'hf - idx, idx};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    r[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    r[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    r[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    r[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return r;
  endfunction

  assign accept = start_i && (fsm_q != RUN);
  assign n_eff  = (rounds_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds_i;
  assign step   = (rem_q < 4'(UNROLL)) ? rem_q : 4'(UNROLL);

  // Rounds beyond the remaining count are skipped so a short last cycle stays exact.
  always_comb begin
    chain = state_q;
    for (int j = 0; j < UNROLL; j++) begin
      if (4'(j) < rem_q) chain = ascon_round(chain, idx_q + 4'(j));
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    unique case (fsm_q)
      IDLE: ;
      RUN: begin
        state_d = chain;
        rem_d   = rem_q - step;
        idx_d   = idx_q + step;
        if (rem_q == step) fsm_d = DONE;
      end
      DONE: if (!start_i) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    if (accept) begin
      state_d = state_i;
      rem_d   = n_eff;
      idx_d   = 4'd12 - n_eff;
      fsm_d   = (n_eff == 4'd0) ? DONE : RUN;
    end
  end

  always_comb begin
    ready_o = (fsm_q != RUN);
    valid_o = (fsm_q == DONE);
    state_o = state_q;
  end

`ifdef ASCON_PERM_BUSY_ERR_EN
  logic err_q, err_d;

  assign err_d = start_i && (fsm_q == RUN);

  always_ff @(posedge clock_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_ascon_perm_iter.sv
// tb/tb_ascon_perm_iter.sv - checks ascon_perm_iter for UNROLL 1..3 against a table-driven reference
module tb_ascon_perm_iter;
  import ascon_perm_pkg::*;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start;
  logic [3:0] rounds_in;
  type_state  state_in;
  logic [2:0] ready, valid;
  type_state  out [3];
`ifdef ASCON_PERM_BUSY_ERR_EN
  logic [2:0] err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ascon_perm_iter #(.UNROLL(g + 1), .MAX_ROUNDS(12)) u_dut (
      .clock_i (clk),
      .reset_i (rst),
      .start_i (start[g]),
      .rounds_i(rounds_in),
      .state_i (state_in),
      .ready_o (ready[g]),
      .valid_o (valid[g]),
`ifdef ASCON_PERM_BUSY_ERR_EN
      .err_o   (err[g]),
`endif
      .state_o (out[g])
    );
  end

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
    logic [127:0] d;
    d = {x, x} >> r;
    return d[63:0];
  endfunction

  // Column-wise S-box lookup (x0 is the MSB of each 5-bit column).
  function automatic type_state model_perm(input type_state s_in, input int r);
    type_state  s, t;
    int         n;
    logic [4:0] v, w;
    s = s_in;
    n = (r > 12) ? 12 : r;
    for (int i = 12 - n; i < 12; i++) begin
      s[2] = s[2] ^ 64'((15 - i) * 16 + i);
      for (int b = 0; b < 64; b++) begin
        v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        w = SBOX[v];
        for (int k = 0; k < 5; k++) t[k][b] = w[4 - k];
      end
      for (int k = 0; k < 5; k++) s[k] = t[k] ^ rotr(t[k], ROT_A[k]) ^ rotr(t[k], ROT_B[k]);
    end
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic run_perm(input int g, input int r, input type_state st, input int busy_at);
    type_state exp_s, held;
    int lat, exp_lat, n;
    exp_s   = model_perm(st, r);
    n       = (r > 12) ? 12 : r;
    exp_lat = (n + g) / (g + 1) + 1;
    @(negedge clk);
    rounds_in = 4'(r);
    state_in  = st;
    start[g]  = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    lat = 1;
    while (valid[g] !== 1'b1 && lat < 40) begin
      chk("ready_low_run", ready[g], 1'b0);
      if (lat == busy_at) start[g] = 1'b1;
      @(posedge clk); #1;
      if (lat == busy_at) begin
        start[g] = 1'b0;
`ifdef ASCON_PERM_BUSY_ERR_EN
        chk("err_pulse", err[g], 1'b1);
`endif
      end
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("result", out[g], exp_s);
    chk("ready_done", ready[g], 1'b1);
`ifdef ASCON_PERM_BUSY_ERR_EN
    chk("err_quiet", err[g], 1'b0);
`endif
    held = out[g];
    @(posedge clk); #1;
    chk("valid_one_cycle", valid[g], 1'b0);
    chk("state_held", out[g], held);
    chk("ready_idle", ready[g], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    type_state sa, sb, pat;
    int lat;

    rst       = 1'b1;
    start     = 3'b000;
    rounds_in = 4'd0;
    state_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_state", out[g], '0);
      chk("rst_valid", valid[g], 1'b0);
      chk("rst_ready", ready[g], 1'b1);
`ifdef ASCON_PERM_BUSY_ERR_EN
      chk("rst_err", err[g], 1'b0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", ready[0], 1'b1);

    run_perm(0, 12, rand_state(), 3);
    run_perm(1, 6, rand_state(), 0);
    run_perm(2, 8, rand_state(), 0);
    pat = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h5555aaaa5555aaaa,
           64'hdeadbeefcafef00d, 64'h0f0f0f0ff0f0f0f0};
    run_perm(0, 0, pat, 0);
    run_perm(2, 0, pat, 0);
    run_perm(1, 15, rand_state(), 0);
    run_perm(2, 15, rand_state(), 0);
    run_perm(1, 7, rand_state(), 2);
    run_perm(2, 1, rand_state(), 0);

    // Back-to-back: start held high through DONE on the UNROLL=2 instance.
    sa = rand_state();
    sb = rand_state();
    @(negedge clk);
    rounds_in = 4'd3;
    state_in  = sa;
    start[1]  = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (valid[1] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat1", lat, 3);
    chk("b2b_out1", out[1], model_perm(sa, 3));
    rounds_in = 4'd5;
    state_in  = sb;
    @(posedge clk); #1;
    chk("b2b_reaccept_ready", ready[1], 1'b0);
    chk("b2b_reaccept_valid", valid[1], 1'b0);
    start[1] = 1'b0;
    lat = 1;
    while (valid[1] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat2", lat, 4);
    chk("b2b_out2", out[1], model_perm(sb, 5));

    // Reset asserted in the third RUN cycle aborts the permutation.
    @(negedge clk);
    rounds_in = 4'd12;
    state_in  = rand_state();
    start[0]  = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_state", out[0], '0);
    chk("abort_valid", valid[0], 1'b0);
    chk("abort_ready", ready[0], 1'b1);
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", valid[0], 1'b0);
    end

    for (int it = 0; it < 24; it++) begin
      run_perm($urandom_range(0, 2), $urandom_range(0, 15), rand_state(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
